// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - in-order ALU sequencer: 4-deep instruction queue, 4x4 regfile, IDLE/EXEC/WB control

module alu_seq_fifo #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [4];
  logic [1:0]   wr_ptr;
  logic [1:0]   rd_ptr;
  logic [2:0]   count;
  logic         do_push;
  logic         do_pop;

  // count is one bit wider than the pointers so 4 entries and 0 entries differ
  assign full    = (count == 3'd4);
  assign empty   = (count == 3'd0);
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // entry storage; occupancy is tracked by count, so the array needs no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // pointers wrap modulo 4 on their own; count follows push/pop balance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

module alu_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [8:0] in_instr,
  output logic       in_ready,
  input  logic       host_we,
  input  logic [1:0] host_addr,
  input  logic [3:0] host_wdata,
  output logic [3:0] host_rdata,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_r,
  input  logic       alu_ovf,
  output logic       done,
  output logic       err,
  output logic       ovf_sticky,
  input  logic       ovf_clr,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [2:0] OP_SUB = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b100;

  state_t     state;
  logic [3:0] regs [4];
  logic [1:0] dst_q;
  logic [2:0] op_q;

  logic       fifo_full;
  logic       fifo_empty;
  logic [8:0] head;
  logic       push;
  logic       pop;

  logic [2:0] head_op;
  logic [1:0] head_dst;
  logic [1:0] head_srca;
  logic [1:0] head_srcb;

  logic       op_legal;
  logic       op_arith;

  assign head_op   = head[8:6];
  assign head_dst  = head[5:4];
  assign head_srca = head[3:2];
  assign head_srcb = head[1:0];

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  // the head is taken only from IDLE, so every instruction spends one IDLE edge
  // after its writeback before the next one reads the regfile
  assign pop      = (state == IDLE) && !fifo_empty;
  assign busy     = !fifo_empty || (state != IDLE);

  assign host_rdata = regs[host_addr];

  // opcodes above AND are illegal; only SUB/ADD may raise overflow
  assign op_legal = (op_q <= OP_AND);
  assign op_arith = (op_q == OP_SUB) || (op_q == OP_ADD);

  alu_seq_fifo #(.W(9)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_instr),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // control FSM with the regfile, operand registers and status pulses it owns
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      for (int i = 0; i < 4; i++) begin
        regs[i] <= 4'd0;
      end
      alu_a      <= 4'd0;
      alu_b      <= 4'd0;
      alu_op     <= 3'b000;
      dst_q      <= 2'd0;
      op_q       <= 3'b000;
      done       <= 1'b0;
      err        <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      // a clear loses to a set on the same edge because the WB set comes later
      if (ovf_clr) begin
        ovf_sticky <= 1'b0;
      end

      // host preload can never collide with writeback: WB implies busy
      if (host_we && !busy) begin
        regs[host_addr] <= host_wdata;
      end

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            alu_a  <= regs[head_srca];
            alu_b  <= regs[head_srcb];
            alu_op <= head_op;
            dst_q  <= head_dst;
            op_q   <= head_op;
            state  <= EXEC;
          end
        end
        EXEC: begin
          state <= WB;
        end
        WB: begin
          state <= IDLE;
          if (op_legal) begin
            regs[dst_q] <= alu_r;
            done        <= 1'b1;
          end else begin
            err <= 1'b1;
          end
          if (op_arith && alu_ovf) begin
            ovf_sticky <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
